// File: rtl/cmprs_frame_ctrl.sv
// Frame sequencer for the compression receive stage: config check/load, block gating, encoder handshake.
// Optional macro CMPRS_TIMEOUT_EN adds an encoder-finish watchdog (TIMEOUT_CYC cycles, err_code 10).
module cmprs_frame_ctrl #(
    parameter int X_LEN       = 11,
    parameter int Y_LEN       = 6,
    parameter int Z_LEN       = 8,
    parameter int Y_BLK       = 32,
    parameter int BLK_W       = 8,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic             sclk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [X_LEN-1:0] X_max_in,
    input  logic [Z_LEN-1:0] Z_max_in,
    input  logic [1:0]       mode_in,
    input  logic [3:0]       id_ratio_in,
    input  logic [BLK_W-1:0] blk_num,
    output logic             cfg_en,
    output logic [X_LEN-1:0] X_max,
    output logic [Z_LEN-1:0] Z_max,
    output logic [1:0]       mode,
    output logic [3:0]       id_ratio,
    input  logic             up_valid,
    output logic             up_ready,
    output logic             dn_valid,
    input  logic             dn_ready,
    input  logic             encode_finish,
    output logic             encode_finish_ready,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [BLK_W-1:0] blk_cnt
);

    localparam int TOT_W = X_LEN + Y_LEN + Z_LEN;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_CFG, S_CALC, S_STREAM, S_WAIT_ENC, S_DONE, S_ERR
    } state_t;

    state_t             state_r, state_nxt_s;
    logic [X_LEN-1:0]   x_max_r;
    logic [Z_LEN-1:0]   z_max_r;
    logic [1:0]         mode_r;
    logic [3:0]         id_ratio_r;
    logic [BLK_W-1:0]   blk_num_r;
    logic [BLK_W-1:0]   blk_cnt_r;
    logic [TOT_W-1:0]   total_r;
    logic [TOT_W-1:0]   pix_cnt_r;
    logic               err_r;
    logic [1:0]         err_code_r;
    logic               cfg_bad_s, beat_s, last_beat_s, release_s, timeout_s, start_acc_s, last_blk_s;

    assign cfg_bad_s = (x_max_r == {X_LEN{1'b0}}) || (z_max_r == {Z_LEN{1'b0}}) ||
                       (mode_r == 2'd3) || (blk_num_r == {BLK_W{1'b0}}) ||
                       !((id_ratio_r == 4'd1) || (id_ratio_r == 4'd4) || (id_ratio_r == 4'd8));
    assign beat_s      = (state_r == S_STREAM) && up_valid && dn_ready;
    assign last_beat_s = beat_s && (pix_cnt_r == (total_r - TOT_W'(1)));
    // abort suppresses the release so no block is counted on an aborted cycle
    assign release_s   = (state_r == S_WAIT_ENC) && encode_finish && !abort;
    assign last_blk_s  = ((blk_cnt_r + BLK_W'(1)) == blk_num_r);
    assign start_acc_s = start && !abort && ((state_r == S_IDLE) || (state_r == S_ERR));

`ifdef CMPRS_TIMEOUT_EN
    localparam int WC_W = $clog2(TIMEOUT_CYC) + 1;
    logic [WC_W-1:0] wait_cnt_r;

    // Watchdog counter: runs only while waiting for the encoder, cleared otherwise
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            wait_cnt_r <= {WC_W{1'b0}};
        end else if ((state_r == S_WAIT_ENC) && !abort) begin
            wait_cnt_r <= wait_cnt_r + WC_W'(1);
        end else begin
            wait_cnt_r <= {WC_W{1'b0}};
        end
    end

    assign timeout_s = (state_r == S_WAIT_ENC) && !encode_finish &&
                       (wait_cnt_r == WC_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_s = 1'b0;
`endif

    // State register
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt_s = state_r;
        if (abort) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE:     state_nxt_s = start ? S_CHECK : S_IDLE;
                S_CHECK:    state_nxt_s = cfg_bad_s ? S_ERR : S_CFG;
                S_CFG:      state_nxt_s = S_CALC;
                S_CALC:     state_nxt_s = S_STREAM;
                S_STREAM:   state_nxt_s = last_beat_s ? S_WAIT_ENC : S_STREAM;
                S_WAIT_ENC: begin
                    if (release_s) begin
                        state_nxt_s = last_blk_s ? S_DONE : S_STREAM;
                    end else if (timeout_s) begin
                        state_nxt_s = S_ERR;
                    end else begin
                        state_nxt_s = S_WAIT_ENC;
                    end
                end
                S_DONE:     state_nxt_s = S_IDLE;
                S_ERR:      state_nxt_s = start ? S_CHECK : S_ERR;
                default:    state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Config latch, pixel/block counters and error status
    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            x_max_r    <= {X_LEN{1'b0}};
            z_max_r    <= {Z_LEN{1'b0}};
            mode_r     <= 2'd0;
            id_ratio_r <= 4'd0;
            blk_num_r  <= {BLK_W{1'b0}};
            blk_cnt_r  <= {BLK_W{1'b0}};
            total_r    <= {TOT_W{1'b0}};
            pix_cnt_r  <= {TOT_W{1'b0}};
            err_r      <= 1'b0;
            err_code_r <= 2'b00;
        end else if (abort) begin
            pix_cnt_r  <= {TOT_W{1'b0}};
            err_r      <= 1'b0;
        end else begin
            if (start_acc_s) begin
                x_max_r    <= X_max_in;
                z_max_r    <= Z_max_in;
                mode_r     <= mode_in;
                id_ratio_r <= id_ratio_in;
                blk_num_r  <= blk_num;
                blk_cnt_r  <= {BLK_W{1'b0}};
                pix_cnt_r  <= {TOT_W{1'b0}};
                err_r      <= 1'b0;
                err_code_r <= 2'b00;
            end
            case (state_r)
                S_CHECK: begin
                    if (cfg_bad_s) begin
                        err_r      <= 1'b1;
                        err_code_r <= 2'b01;
                    end
                end
                S_CALC:   total_r <= TOT_W'(x_max_r) * TOT_W'(Y_BLK) * TOT_W'(z_max_r);
                S_STREAM: begin
                    if (last_beat_s) begin
                        pix_cnt_r <= {TOT_W{1'b0}};
                    end else if (beat_s) begin
                        pix_cnt_r <= pix_cnt_r + TOT_W'(1);
                    end
                end
                S_WAIT_ENC: begin
                    if (release_s) begin
                        blk_cnt_r <= blk_cnt_r + BLK_W'(1);
                    end else if (timeout_s) begin
                        err_r      <= 1'b1;
                        err_code_r <= 2'b10;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg_en              = (state_r == S_CFG);
    assign done                = (state_r == S_DONE);
    assign busy                = (state_r != S_IDLE) && (state_r != S_DONE) && (state_r != S_ERR);
    assign dn_valid            = (state_r == S_STREAM) && up_valid;
    assign up_ready            = (state_r == S_STREAM) && dn_ready;
    assign encode_finish_ready = release_s;
    assign X_max               = x_max_r;
    assign Z_max               = z_max_r;
    assign mode                = mode_r;
    assign id_ratio            = id_ratio_r;
    assign err                 = err_r;
    assign err_code            = err_code_r;
    assign blk_cnt             = blk_cnt_r;

endmodule

// File: tb/tb_cmprs_frame_ctrl.sv
// Directed self-checking bench for cmprs_frame_ctrl (4x32x2 = 256-pixel blocks).
// Define CMPRS_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYC = 16.
module tb_cmprs_frame_ctrl;

    logic        sclk = 1'b0;
    logic        rst_n, start, abort;
    logic [10:0] X_max_in;
    logic [7:0]  Z_max_in;
    logic [1:0]  mode_in;
    logic [3:0]  id_ratio_in;
    logic [7:0]  blk_num;
    logic        cfg_en;
    logic [10:0] X_max;
    logic [7:0]  Z_max;
    logic [1:0]  mode;
    logic [3:0]  id_ratio;
    logic        up_valid, up_ready, dn_valid, dn_ready;
    logic        encode_finish, encode_finish_ready;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [7:0]  blk_cnt;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    cmprs_frame_ctrl #(.TIMEOUT_CYC(16)) dut (
        .sclk(sclk), .rst_n(rst_n), .start(start), .abort(abort),
        .X_max_in(X_max_in), .Z_max_in(Z_max_in), .mode_in(mode_in),
        .id_ratio_in(id_ratio_in), .blk_num(blk_num), .cfg_en(cfg_en),
        .X_max(X_max), .Z_max(Z_max), .mode(mode), .id_ratio(id_ratio),
        .up_valid(up_valid), .up_ready(up_ready), .dn_valid(dn_valid), .dn_ready(dn_ready),
        .encode_finish(encode_finish), .encode_finish_ready(encode_finish_ready),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .blk_cnt(blk_cnt)
    );

    task automatic cycle();
        @(posedge sclk);
        #1;
    endtask

    task automatic do_start(input logic [10:0] x, input logic [7:0] z, input logic [1:0] m,
                            input logic [3:0] r, input logic [7:0] n);
        X_max_in = x; Z_max_in = z; mode_in = m; id_ratio_in = r; blk_num = n;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    // Runs ncyc cycles with up_valid=1, recording beats and output pulses (sampled at negedge).
    task automatic run_cycles(input int ncyc, input bit toggle, output int beats, output int rels,
                              output int dones, output int first_rel, output int last_rel,
                              output int first_done);
        beats = 0; rels = 0; dones = 0; first_rel = -1; last_rel = -1; first_done = -1;
        for (int i = 0; i < ncyc; i++) begin
            up_valid = 1'b1;
            if (toggle) dn_ready = ~dn_ready;
            else dn_ready = 1'b1;
            @(negedge sclk);
            if (dn_valid && dn_ready) beats++;
            if (encode_finish_ready) begin
                rels++;
                if (first_rel < 0) first_rel = i;
                last_rel = i;
            end
            if (done) begin
                dones++;
                if (first_done < 0) first_done = i;
            end
            cycle();
        end
        up_valid = 1'b0;
    endtask

    task automatic release_blk(output bit seen);
        encode_finish = 1'b1;
        @(negedge sclk);
        seen = encode_finish_ready;
        cycle();
        encode_finish = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; X_max_in = 11'd7; Z_max_in = 8'd3;
        mode_in = 2'd1; id_ratio_in = 4'd1; blk_num = 8'd1;
        up_valid = 1'b1; dn_ready = 1'b1; encode_finish = 1'b1;
        repeat (3) cycle();
        checks++;
        if ({cfg_en, dn_valid, up_ready, encode_finish_ready, busy, done, err} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000000",
                {cfg_en, dn_valid, up_ready, encode_finish_ready, busy, done, err});
        end
        checks++;
        if ({X_max, Z_max, mode, id_ratio, err_code, blk_cnt} !== 35'd0) begin
            errors++; $display("FAIL reset_regs: X=%0d Z=%0d mode=%0d ratio=%0d code=%0d blk=%0d expected all 0",
                X_max, Z_max, mode, id_ratio, err_code, blk_cnt);
        end
        rst_n = 1'b1; up_valid = 1'b0; encode_finish = 1'b0;
        cycle();
    endtask

    task automatic test_single_block();
        int b, r, d, fr, lr, fd;
        bit seen;
        do_start(11'd4, 8'd2, 2'd0, 4'd4, 8'd1);
        checks++;
        if (busy !== 1'b1 || cfg_en !== 1'b0) begin
            errors++; $display("FAIL single_check_state: busy=%b cfg_en=%b expected 1 0", busy, cfg_en);
        end
        cycle();
        checks++;
        if (cfg_en !== 1'b1) begin
            errors++; $display("FAIL single_cfg_en: got %b expected 1", cfg_en);
        end
        checks++;
        if (X_max !== 11'd4 || Z_max !== 8'd2 || mode !== 2'd0 || id_ratio !== 4'd4) begin
            errors++; $display("FAIL single_latch: X=%0d Z=%0d mode=%0d ratio=%0d expected 4 2 0 4",
                X_max, Z_max, mode, id_ratio);
        end
        cycle();
        checks++;
        if (cfg_en !== 1'b0 || up_ready !== 1'b0) begin
            errors++; $display("FAIL single_calc: cfg_en=%b up_ready=%b expected 0 0", cfg_en, up_ready);
        end
        cycle();
        up_valid = 1'b1;
        #1;
        checks++;
        if (up_ready !== 1'b1 || dn_valid !== 1'b1) begin
            errors++; $display("FAIL single_stream_open: up_ready=%b dn_valid=%b expected 1 1", up_ready, dn_valid);
        end
        run_cycles(400, 1'b0, b, r, d, fr, lr, fd);
        checks++;
        if (b !== 256 || r !== 0 || d !== 0) begin
            errors++; $display("FAIL single_beats: beats=%0d rel=%0d done=%0d expected 256 0 0", b, r, d);
        end
        up_valid = 1'b1;
        #1;
        checks++;
        if (up_ready !== 1'b0 || dn_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL single_wait_enc: up_ready=%b dn_valid=%b busy=%b expected 0 0 1",
                up_ready, dn_valid, busy);
        end
        up_valid = 1'b0;
        release_blk(seen);
        checks++;
        if (seen !== 1'b1) begin
            errors++; $display("FAIL single_release: got %b expected 1", seen);
        end
        checks++;
        if (done !== 1'b1 || blk_cnt !== 8'd1 || encode_finish_ready !== 1'b0) begin
            errors++; $display("FAIL single_done: done=%b blk_cnt=%0d efr=%b expected 1 1 0",
                done, blk_cnt, encode_finish_ready);
        end
        cycle();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_idle: done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_multi_block();
        int b, r, d, fr, lr, fd;
        bit seen;
        do_start(11'd4, 8'd2, 2'd2, 4'd1, 8'd3);
        repeat (3) cycle();
        for (int k = 0; k < 3; k++) begin
            run_cycles(700, 1'b1, b, r, d, fr, lr, fd);
            checks++;
            if (b !== 256 || r !== 0 || d !== 0 || blk_cnt !== k[7:0]) begin
                errors++; $display("FAIL multi_block%0d: beats=%0d rel=%0d done=%0d blk_cnt=%0d expected 256 0 0 %0d",
                    k, b, r, d, blk_cnt, k);
            end
            release_blk(seen);
            checks++;
            if (seen !== 1'b1 || done !== (k == 2) || busy !== (k != 2)) begin
                errors++; $display("FAIL multi_release%0d: rel=%b done=%b busy=%b expected 1 %0d %0d",
                    k, seen, done, busy, k == 2, k != 2);
            end
        end
        checks++;
        if (blk_cnt !== 8'd3) begin
            errors++; $display("FAIL multi_blk_cnt: got %0d expected 3", blk_cnt);
        end
        cycle();
    endtask

    task automatic test_bad_config();
        logic [10:0] xs [4] = '{11'd4, 11'd4, 11'd0, 11'd4};
        logic [1:0]  ms [4] = '{2'd3, 2'd0, 2'd0, 2'd0};
        logic [3:0]  rs [4] = '{4'd4, 4'd2, 4'd4, 4'd4};
        logic [7:0]  ns [4] = '{8'd1, 8'd1, 8'd1, 8'd0};
        int b, r, d, fr, lr, fd;
        bit seen;
        for (int i = 0; i < 4; i++) begin
            do_start(xs[i], 8'd2, ms[i], rs[i], ns[i]);
            checks++;
            if (cfg_en !== 1'b0) begin
                errors++; $display("FAIL bad%0d_cfg_en_check: got %b expected 0", i, cfg_en);
            end
            cycle();
            checks++;
            if (cfg_en !== 1'b0 || err !== 1'b1 || err_code !== 2'b01 || busy !== 1'b0) begin
                errors++; $display("FAIL bad%0d_err: cfg_en=%b err=%b code=%b busy=%b expected 0 1 01 0",
                    i, cfg_en, err, err_code, busy);
            end
            cycle();
            checks++;
            if (err !== 1'b1) begin
                errors++; $display("FAIL bad%0d_err_held: got %b expected 1", i, err);
            end
        end
        do_start(11'd4, 8'd2, 2'd1, 4'd8, 8'd1);
        checks++;
        if (err !== 1'b0 || err_code !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL bad_recover: err=%b code=%b busy=%b expected 0 00 1", err, err_code, busy);
        end
        repeat (3) cycle();
        run_cycles(300, 1'b0, b, r, d, fr, lr, fd);
        release_blk(seen);
        checks++;
        if (b !== 256 || seen !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL bad_recover_run: beats=%0d rel=%b done=%b expected 256 1 1", b, seen, done);
        end
        cycle();
    endtask

    task automatic test_abort();
        int b, r, d, fr, lr, fd;
        bit seen;
        do_start(11'd4, 8'd2, 2'd0, 4'd4, 8'd1);
        repeat (3) cycle();
        run_cycles(100, 1'b0, b, r, d, fr, lr, fd);
        checks++;
        if (b !== 100) begin
            errors++; $display("FAIL abort_pre_beats: got %0d expected 100", b);
        end
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++;
        if (up_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || X_max !== 11'd4) begin
            errors++; $display("FAIL abort_idle: up_ready=%b busy=%b done=%b err=%b X=%0d expected 0 0 0 0 4",
                up_ready, busy, done, err, X_max);
        end
        run_cycles(5, 1'b0, b, r, d, fr, lr, fd);
        checks++;
        if (b !== 0 || d !== 0) begin
            errors++; $display("FAIL abort_quiet: beats=%0d done=%0d expected 0 0", b, d);
        end
        start = 1'b1; abort = 1'b1;
        cycle();
        start = 1'b0; abort = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL abort_vs_start: busy=%b expected 0", busy);
        end
        do_start(11'd4, 8'd2, 2'd0, 4'd4, 8'd1);
        repeat (3) cycle();
        run_cycles(300, 1'b0, b, r, d, fr, lr, fd);
        release_blk(seen);
        checks++;
        if (b !== 256 || done !== 1'b1 || blk_cnt !== 8'd1) begin
            errors++; $display("FAIL abort_restart: beats=%0d done=%b blk_cnt=%0d expected 256 1 1", b, done, blk_cnt);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        int b, r, d, fr, lr, fd;
        do_start(11'd4, 8'd2, 2'd0, 4'd8, 8'd2);
        repeat (3) cycle();
        encode_finish = 1'b1;
        run_cycles(600, 1'b0, b, r, d, fr, lr, fd);
        encode_finish = 1'b0;
        checks++;
        if (b !== 512 || r !== 2 || d !== 1) begin
            errors++; $display("FAIL b2b_counts: beats=%0d rel=%0d done=%0d expected 512 2 1", b, r, d);
        end
        checks++;
        if (fr !== 256 || lr !== 513 || fd !== 514 || blk_cnt !== 8'd2) begin
            errors++; $display("FAIL b2b_timing: rel@%0d,%0d done@%0d blk=%0d expected 256,513 514 2",
                fr, lr, fd, blk_cnt);
        end
    endtask

    task automatic test_timeout();
        int b, r, d, fr, lr, fd;
        do_start(11'd4, 8'd2, 2'd0, 4'd4, 8'd1);
        repeat (3) cycle();
        run_cycles(256, 1'b0, b, r, d, fr, lr, fd);
`ifdef CMPRS_TIMEOUT_EN
        repeat (15) cycle();
        checks++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL timeout_early: err=%b busy=%b expected 0 1", err, busy);
        end
        cycle();
        checks++;
        if (err !== 1'b1 || err_code !== 2'b10 || busy !== 1'b0) begin
            errors++; $display("FAIL timeout_err: err=%b code=%b busy=%b expected 1 10 0", err, err_code, busy);
        end
`else
        repeat (10000) cycle();
        checks++;
        if (busy !== 1'b1 || err !== 1'b0 || err_code !== 2'b00 || up_ready !== 1'b0) begin
            errors++; $display("FAIL no_timeout: busy=%b err=%b code=%b up_ready=%b expected 1 0 00 0",
                busy, err, err_code, up_ready);
        end
`endif
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL timeout_abort: busy=%b err=%b expected 0 0", busy, err);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_multi_block();
        test_bad_config();
        test_abort();
        test_back_to_back();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
